// File: rtl/step_rate_controller_if.sv
// Button/lock inputs and step outputs of step_rate_controller.
// master = board/bench side, slave = controller side.
interface step_rate_controller_if #(
    parameter int SHIFT_W   = 3,
    parameter int SHIFT_MAX = 7
);
    logic                 pll_locked;
    logic [1:0]           btn;
    logic [SHIFT_W-1:0]   shift_amount;
    logic [SHIFT_MAX:0]   step_val;
    logic                 count_en;
    logic                 shift_changed;
    logic                 limit_hit;
    logic                 conflict;

    modport master (
        output pll_locked, btn,
        input  shift_amount, step_val, count_en, shift_changed, limit_hit, conflict
    );

    modport slave (
        input  pll_locked, btn,
        output shift_amount, step_val, count_en, shift_changed, limit_hit, conflict
    );
endinterface

// File: rtl/step_rate_controller.sv
// Step-exponent sequencer for the LED counter: debounces two buttons on a slow tick
// and steps a saturating shift value. Hold-to-repeat is enabled by `define BTN_REPEAT_EN.
module step_rate_controller #(
    parameter int TICK_BITS      = 17,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int SHIFT_W        = 3,
    parameter int SHIFT_MAX      = 7,
    parameter int SHIFT_INIT     = 0,
    parameter int HOLD_TICKS     = 100,
    parameter int REPEAT_TICKS   = 25
) (
    input logic                   clk_50m,
    input logic                   rst,
    step_rate_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS, HELD} btn_state_e;

    localparam int DB_W   = 6;
    localparam int STEP_W = SHIFT_MAX + 1;

    logic [1:0]           btn_meta, btn_sync;
    logic [1:0]           pressed;
    logic [TICK_BITS-1:0] presc;
    logic                 tick;
    logic                 count_en_q;

    btn_state_e           state_q [2];
    btn_state_e           state_d [2];
    logic [DB_W-1:0]      cnt_q   [2];
    logic [DB_W-1:0]      cnt_d   [2];
    logic [1:0]           ev;

    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [STEP_W-1:0]    step_q;
    logic                 chg_q, lim_q, conf_q;
    logic                 chg_d, lim_d, conf_d;

`ifdef BTN_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0]    hold_q [2];
    logic [HOLD_W-1:0]    hold_d [2];
    logic [HOLD_W-1:0]    hold_inc [2];
    logic [1:0]           rep_q, rep_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{HOLD_TICKS, REPEAT_TICKS};
`endif

    assign pressed = ~btn_sync;
    // The tick is the cycle in which the prescaler wraps; it is gated by lock like the count.
    assign tick    = bus.pll_locked & (&presc);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            ev[b]      = 1'b0;
`ifdef BTN_REPEAT_EN
            hold_inc[b] = hold_q[b] + HOLD_W'(1);
            hold_d[b]   = (state_q[b] == HELD) ? hold_q[b] : '0;
            rep_d[b]    = (state_q[b] == HELD) ? rep_q[b]  : 1'b0;
`endif
            if (tick) begin
                unique case (state_q[b])
                    IDLE: begin
                        if (pressed[b]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_d[b] = HELD;
                            end else begin
                                state_d[b] = PRESS;
                                cnt_d[b]   = DB_W'(1);
                            end
                        end
                    end
                    PRESS: begin
                        if (!pressed[b]) begin
                            state_d[b] = IDLE;
                            cnt_d[b]   = '0;
                        end else if (cnt_q[b] + DB_W'(1) == DB_W'(DEBOUNCE_TICKS)) begin
                            state_d[b] = HELD;
                            cnt_d[b]   = '0;
                        end else begin
                            cnt_d[b]   = cnt_q[b] + DB_W'(1);
                        end
                    end
                    HELD: begin
                        if (!pressed[b]) begin
                            state_d[b] = IDLE;
`ifdef BTN_REPEAT_EN
                            ev[b]      = ~rep_q[b];
                        end else if (!rep_q[b] && hold_inc[b] == HOLD_W'(HOLD_TICKS)) begin
                            ev[b]      = 1'b1;
                            rep_d[b]   = 1'b1;
                            hold_d[b]  = '0;
                        end else if (rep_q[b] && hold_inc[b] == HOLD_W'(REPEAT_TICKS)) begin
                            ev[b]      = 1'b1;
                            hold_d[b]  = '0;
                        end else begin
                            hold_d[b]  = hold_inc[b];
`else
                            ev[b]      = 1'b1;
`endif
                        end
                    end
                    default: state_d[b] = IDLE;
                endcase
            end
        end
    end

    // Up and down arbitration; saturation absorbs the event and reports it on limit_hit.
    always_comb begin
        shift_d = shift_q;
        chg_d   = 1'b0;
        lim_d   = 1'b0;
        conf_d  = 1'b0;
        if (ev == 2'b11) begin
            conf_d = 1'b1;
        end else if (ev[0]) begin
            if (shift_q == SHIFT_W'(SHIFT_MAX)) begin
                lim_d = 1'b1;
            end else begin
                shift_d = shift_q + SHIFT_W'(1);
                chg_d   = 1'b1;
            end
        end else if (ev[1]) begin
            if (shift_q == '0) begin
                lim_d = 1'b1;
            end else begin
                shift_d = shift_q - SHIFT_W'(1);
                chg_d   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            btn_meta   <= '1;
            btn_sync   <= '1;
            presc      <= '0;
            count_en_q <= 1'b0;
            shift_q    <= SHIFT_W'(SHIFT_INIT);
            step_q     <= STEP_W'(1) << SHIFT_INIT;
            chg_q      <= 1'b0;
            lim_q      <= 1'b0;
            conf_q     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
`ifdef BTN_REPEAT_EN
                hold_q[b]  <= '0;
                rep_q[b]   <= 1'b0;
`endif
            end
        end else begin
            btn_meta   <= bus.btn;
            btn_sync   <= btn_meta;
            count_en_q <= bus.pll_locked;
            if (bus.pll_locked) begin
                presc <= presc + TICK_BITS'(1);
            end
            shift_q    <= shift_d;
            step_q     <= STEP_W'(1) << shift_d;
            chg_q      <= chg_d;
            lim_q      <= lim_d;
            conf_q     <= conf_d;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
`ifdef BTN_REPEAT_EN
                hold_q[b]  <= hold_d[b];
                rep_q[b]   <= rep_d[b];
`endif
            end
        end
    end

    assign bus.shift_amount  = shift_q;
    assign bus.step_val      = step_q;
    assign bus.count_en      = count_en_q;
    assign bus.shift_changed = chg_q;
    assign bus.limit_hit     = lim_q;
    assign bus.conflict      = conf_q;
endmodule

// File: tb/tb_step_rate_controller.sv
// Self-checking bench for step_rate_controller: directed and random button/lock/reset
// stimulus compared every cycle against a tick-level behavioural model.
module tb_step_rate_controller;
    localparam int TICK_BITS      = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int SHIFT_W        = 3;
    localparam int SHIFT_MAX      = 7;
    localparam int SHIFT_INIT     = 0;
    localparam int HOLD_TICKS     = 4;
    localparam int REPEAT_TICKS   = 2;
    localparam int TICK_CYC       = 1 << TICK_BITS;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    always #10 clk_50m = ~clk_50m;

    step_rate_controller_if #(.SHIFT_W(SHIFT_W), .SHIFT_MAX(SHIFT_MAX)) bus ();

    step_rate_controller #(
        .TICK_BITS(TICK_BITS), .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .SHIFT_W(SHIFT_W),
        .SHIFT_MAX(SHIFT_MAX), .SHIFT_INIT(SHIFT_INIT), .HOLD_TICKS(HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clk_50m(clk_50m),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a tick every TICK_CYC locked cycles, each button summarised by its
    // run of consecutive pressed ticks; events follow from the run length alone.
    int         m_presc = 0;
    int         m_run [2] = '{0, 0};
    int         m_shift = SHIFT_INIT;
    bit         m_en = 1'b0, m_chg = 1'b0, m_lim = 1'b0, m_conf = 1'b0;
    logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11;

    function automatic bit release_event(input int run);
`ifdef BTN_REPEAT_EN
        return (run >= DEBOUNCE_TICKS) && (run < DEBOUNCE_TICKS + HOLD_TICKS);
`else
        return run >= DEBOUNCE_TICKS;
`endif
    endfunction

    function automatic bit repeat_event(input int run);
`ifdef BTN_REPEAT_EN
        int extra = run - DEBOUNCE_TICKS - HOLD_TICKS;
        return (extra >= 0) && (extra % REPEAT_TICKS == 0);
`else
        return (run < 0);
`endif
    endfunction

    always @(posedge clk_50m) begin
        bit   ev [2];
        bit   tick;
        logic [1:0] seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.btn;
        if (rst) begin
            m_presc = 0;
            m_run   = '{0, 0};
            m_shift = SHIFT_INIT;
            m_en    = 1'b0;
            m_chg   = 1'b0;
            m_lim   = 1'b0;
            m_conf  = 1'b0;
        end else begin
            m_en   = bus.pll_locked;
            m_chg  = 1'b0;
            m_lim  = 1'b0;
            m_conf = 1'b0;
            tick   = 1'b0;
            if (bus.pll_locked) begin
                tick    = (m_presc == TICK_CYC - 1);
                m_presc = (m_presc + 1) % TICK_CYC;
            end
            if (tick) begin
                for (int b = 0; b < 2; b++) begin
                    ev[b] = 1'b0;
                    if (!seen[b]) begin
                        m_run[b]++;
                        ev[b] = repeat_event(m_run[b]);
                    end else begin
                        ev[b]    = release_event(m_run[b]);
                        m_run[b] = 0;
                    end
                end
                if (ev[0] && ev[1]) begin
                    m_conf = 1'b1;
                end else if (ev[0]) begin
                    if (m_shift == SHIFT_MAX) m_lim = 1'b1;
                    else begin m_shift++; m_chg = 1'b1; end
                end else if (ev[1]) begin
                    if (m_shift == 0) m_lim = 1'b1;
                    else begin m_shift--; m_chg = 1'b1; end
                end
            end
        end
    end

    always @(negedge clk_50m) begin
        if (chk_en) begin
            check("shift_amount",  32'(bus.shift_amount),  32'(m_shift));
            check("step_val",      32'(bus.step_val),      32'(1) << m_shift);
            check("count_en",      32'(bus.count_en),      32'(m_en));
            check("shift_changed", 32'(bus.shift_changed), 32'(m_chg));
            check("limit_hit",     32'(bus.limit_hit),     32'(m_lim));
            check("conflict",      32'(bus.conflict),      32'(m_conf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic hold(input logic [1:0] b, input int nticks);
        bus.btn = b;
        cycles(nticks * TICK_CYC);
    endtask

    task automatic press(input int idx, input int nticks);
        logic [1:0] b;
        b      = 2'b11;
        b[idx] = 1'b0;
        hold(b, nticks);
        hold(2'b11, 2);
    endtask

    initial begin
        bus.pll_locked = 1'b1;
        bus.btn        = 2'b11;
        rst            = 1'b1;
        cycles(1);
        chk_en = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(3);

        press(0, 4);                           // valid press: 0 -> 1
        press(0, 2);                           // bounce: no event
        repeat (7) press(0, 4);                // climb to 7, last press saturates
        repeat (8) press(1, 4);                // descend to 0, last press saturates
        hold(2'b00, 4);                        // both armed, released together
        hold(2'b11, 2);

        bus.btn = 2'b10;                       // lock loss in the middle of debounce
        cycles(20);
        bus.pll_locked = 1'b0;
        cycles(40);
        bus.pll_locked = 1'b1;
        cycles(3 * TICK_CYC);
        hold(2'b11, 2);

        bus.btn = 2'b10;                       // reset mid-press, button held through it
        cycles(40);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2 * TICK_CYC);
        hold(2'b11, 2);

`ifdef BTN_REPEAT_EN
        hold(2'b10, DEBOUNCE_TICKS + 2 * HOLD_TICKS);
        hold(2'b11, 2);
`endif

        for (int i = 0; i < 150; i++) begin
            bus.btn = 2'($urandom_range(0, 3));
            cycles($urandom_range(1, 6) * TICK_CYC + $urandom_range(0, TICK_CYC - 1));
            if ($urandom_range(0, 11) == 0) begin
                bus.pll_locked = 1'b0;
                cycles($urandom_range(5, 50));
                bus.pll_locked = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        hold(2'b11, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
